multi_valid_move_scanner: RTL and testbench

Time-multiplexed, parametrised move legality engine for NUM_CH characters (pacman plus ghosts), sharing one map block-memory read port.
- On start, snapshots every character's display position and converts it to a tile (col,row).
- Reads the above, same and below map rows for each character in turn.
- Publishes one-hot-per-direction valid-move nibbles {Left,Down,Up,Right}.
- Sits between the character position registers and the movement/AI controllers.
- Map bits: 1 = passable (food or empty), 0 = wall.

---
 rtl/vmd_pkg.sv | 20 ++
 rtl/vmd_pos_to_tile.sv | 22 ++
 rtl/multi_valid_move_scanner.sv | 178 +++++++++++++++++
 tb/tb_multi_valid_move_scanner.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vmd_pkg.sv
// Shared types and helpers for the multi-channel valid-move scanner.
// Direction bit positions inside each nibble, scan FSM states, tunnel wrap.
package vmd_pkg;

  localparam int DIR_RIGHT = 0;
  localparam int DIR_UP    = 1;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 3;

  typedef enum logic [2:0] {IDLE, RD_A, RD_S, RD_B, WR, DONE} state_t;

  function automatic int unsigned wrap_left(input int unsigned col, input int unsigned map_w);
    return (col == 0) ? map_w - 1 : col - 1;
  endfunction

  function automatic int unsigned wrap_right(input int unsigned col, input int unsigned map_w);
    return (col >= map_w - 1) ? 0 : col + 1;
  endfunction

endpackage

// File: rtl/vmd_pos_to_tile.sv
// Display position to map tile conversion with map bounds check.
module vmd_pos_to_tile #(
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int TILE_SHIFT = 3,
  parameter int MAP_W      = 80,
  parameter int MAP_H      = 60,
  parameter int COL_W      = X_W - TILE_SHIFT,
  parameter int ROW_W      = Y_W - TILE_SHIFT
) (
  input  logic [X_W-1:0]   pos_x,
  input  logic [Y_W-1:0]   pos_y,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             in_range
);

  assign col      = COL_W'(pos_x >> TILE_SHIFT);
  assign row      = ROW_W'(pos_y >> TILE_SHIFT);
  assign in_range = (32'(col) < MAP_W) && (32'(row) < MAP_H);

endmodule

// File: rtl/multi_valid_move_scanner.sv
// Time-multiplexed legal-move scanner: one map read port shared by NUM_CH characters.
// Optional on_wall output is built when VMD_ON_WALL_EN is defined.
module multi_valid_move_scanner
  import vmd_pkg::*;
#(
  parameter int NUM_CH     = 5,
  parameter int MAP_W      = 80,
  parameter int MAP_H      = 60,
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int TILE_SHIFT = 3,
  parameter int ROW_AW     = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [X_W*NUM_CH-1:0] pos_x_flat,
  input  logic [Y_W*NUM_CH-1:0] pos_y_flat,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_en,
  output logic [ROW_AW-1:0]     mem_addr,
  input  logic [MAP_W-1:0]      mem_rdata,
  output logic [4*NUM_CH-1:0]   moves_flat,
  output logic [NUM_CH-1:0]     moves_valid
`ifdef VMD_ON_WALL_EN
  ,
  output logic [NUM_CH-1:0]     on_wall
`endif
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int COL_W = X_W - TILE_SHIFT;
  localparam int ROW_W = Y_W - TILE_SHIFT;
  localparam int CI_W  = $clog2(MAP_W);

  state_t          state, state_nxt;
  logic [CH_W-1:0] ch;
  logic [X_W-1:0]  snap_x [NUM_CH];
  logic [Y_W-1:0]  snap_y [NUM_CH];

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              in_range;
  logic [CI_W-1:0]   ci, ci_l, ci_r;
  logic [ROW_AW-1:0] ra;
  logic              at_top, at_bot, last_ch;
  logic              above_p1, same_l_p2, same_r_p2;
  logic [3:0]        nib;

  vmd_pos_to_tile #(
    .X_W(X_W), .Y_W(Y_W), .TILE_SHIFT(TILE_SHIFT), .MAP_W(MAP_W), .MAP_H(MAP_H)
  ) u_tile (
    .pos_x    (snap_x[ch]),
    .pos_y    (snap_y[ch]),
    .col      (col),
    .row      (row),
    .in_range (in_range)
  );

  // Out-of-range tiles collapse to index 0 so every address and bit select stays legal.
  assign ci      = in_range ? CI_W'(col) : '0;
  assign ra      = in_range ? ROW_AW'(row) : '0;
  assign ci_l    = CI_W'(wrap_left(32'(ci), MAP_W));
  assign ci_r    = CI_W'(wrap_right(32'(ci), MAP_W));
  assign at_top  = (ra == '0);
  assign at_bot  = (ra == ROW_AW'(MAP_H - 1));
  assign last_ch = (ch == CH_W'(NUM_CH - 1));

  // Snapshot positions at start; later input changes cannot disturb a pass.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int i = 0; i < NUM_CH; i++) begin
        snap_x[i] <= pos_x_flat[X_W*i +: X_W];
        snap_y[i] <= pos_y_flat[Y_W*i +: Y_W];
      end
    end
  end

  // Stage p1: above row arrives in RD_S
  always_ff @(posedge clk) begin
    if (state == RD_S) above_p1 <= mem_rdata[ci];
  end

  // Stage p2: same row arrives in RD_B
  always_ff @(posedge clk) begin
    if (state == RD_B) begin
      same_l_p2 <= mem_rdata[ci_l];
      same_r_p2 <= mem_rdata[ci_r];
    end
  end

`ifdef VMD_ON_WALL_EN
  logic same_c_p2;
  always_ff @(posedge clk) begin
    if (state == RD_B) same_c_p2 <= mem_rdata[ci];
  end
`endif

  // Stage p3: below row arrives in WR and the nibble is assembled
  always_comb begin
    nib = '0;
    if (in_range) begin
      nib[DIR_RIGHT] = same_r_p2;
      nib[DIR_UP]    = above_p1 & ~at_top;
      nib[DIR_DOWN]  = mem_rdata[ci] & ~at_bot;
      nib[DIR_LEFT]  = same_l_p2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ch          <= '0;
      moves_flat  <= '0;
      moves_valid <= '0;
`ifdef VMD_ON_WALL_EN
      on_wall     <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        ch          <= '0;
        moves_valid <= '0;
`ifdef VMD_ON_WALL_EN
        on_wall     <= '0;
`endif
      end
      if (state == WR) begin
        moves_flat[{ch, 2'b00} +: 4] <= nib;
        moves_valid[ch]              <= 1'b1;
`ifdef VMD_ON_WALL_EN
        on_wall[ch]                  <= in_range & ~same_c_p2;
`endif
        if (!last_ch) ch <= ch + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_addr  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RD_A;
      RD_A: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_addr  = at_top ? ra : ra - 1'b1;
        state_nxt = RD_S;
      end
      RD_S: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_addr  = ra;
        state_nxt = RD_B;
      end
      RD_B: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_addr  = (at_bot || !in_range) ? ra : ra + 1'b1;
        state_nxt = WR;
      end
      WR: begin
        busy      = 1'b1;
        state_nxt = last_ch ? DONE : RD_A;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multi_valid_move_scanner.sv
// Directed bench for multi_valid_move_scanner with a behavioural map memory.
module tb_multi_valid_move_scanner;

  localparam int NUM_CH = 5;
  localparam int MAP_W  = 80;
  localparam int MAP_H  = 60;
  localparam int X_W    = 11;
  localparam int Y_W    = 10;
  localparam int ROW_AW = 6;

  logic                  clk = 1'b0;
  logic                  rst, start;
  logic [X_W*NUM_CH-1:0] pos_x_flat;
  logic [Y_W*NUM_CH-1:0] pos_y_flat;
  logic                  busy, done, mem_en;
  logic [ROW_AW-1:0]     mem_addr;
  logic [MAP_W-1:0]      mem_rdata;
  logic [4*NUM_CH-1:0]   moves_flat;
  logic [NUM_CH-1:0]     moves_valid;
`ifdef VMD_ON_WALL_EN
  logic [NUM_CH-1:0]     on_wall;
`endif

  logic [MAP_W-1:0] map [MAP_H];
  int n_checks = 0;
  int n_errors = 0;
  int addr_bad = 0;
  int lat;

  multi_valid_move_scanner #(
    .NUM_CH(NUM_CH), .MAP_W(MAP_W), .MAP_H(MAP_H), .X_W(X_W), .Y_W(Y_W),
    .TILE_SHIFT(3), .ROW_AW(ROW_AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pos_x_flat  (pos_x_flat),
    .pos_y_flat  (pos_y_flat),
    .busy        (busy),
    .done        (done),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .moves_flat  (moves_flat),
    .moves_valid (moves_valid)
`ifdef VMD_ON_WALL_EN
    ,
    .on_wall     (on_wall)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= map[mem_addr];
      if (mem_addr > ROW_AW'(MAP_H - 1)) addr_bad++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_map(input logic v);
    for (int r = 0; r < MAP_H; r++) map[r] = {MAP_W{v}};
  endtask

  task automatic set_pos(input int i, input int c, input int r);
    pos_x_flat[X_W*i +: X_W] = X_W'(c * 8 + 2);
    pos_y_flat[Y_W*i +: Y_W] = Y_W'(r * 8 + 5);
  endtask

  task automatic park();
    for (int i = 0; i < NUM_CH; i++) set_pos(i, 40, 40);
  endtask

  function automatic logic [3:0] nib(input int i);
    return moves_flat[4*i +: 4];
  endfunction

  task automatic run_pass(input string tag, output int l);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    l = 1;
    while (!done && l < 100) begin
      @(negedge clk);
      l++;
    end
    check_eq({tag, "_latency"}, l, 21);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, done, 1'b0);
    check_eq({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    int n_done, first_done;
    rst = 1'b1;
    start = 1'b0;
    park();
    clear_map(1'b0);
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_mem_en", mem_en, 1'b0);
    check_eq("rst_mem_addr", mem_addr, '0);
    check_eq("rst_moves_flat", moves_flat, '0);
    check_eq("rst_moves_valid", moves_valid, '0);
    rst = 1'b0;

    // Open cross around (10,10)
    map[9][10] = 1'b1; map[11][10] = 1'b1;
    map[10][9] = 1'b1; map[10][10] = 1'b1; map[10][11] = 1'b1;
    set_pos(0, 10, 10);
    run_pass("cross", lat);
    check_eq("cross_nib0", nib(0), 4'b1111);
    check_eq("cross_nib1", nib(1), 4'b0000);
    check_eq("cross_valid", moves_valid, 5'b11111);

    // Horizontal corridor, character inside a wall tile
    clear_map(1'b0);
    map[10][9] = 1'b1; map[10][11] = 1'b1;
    run_pass("corr", lat);
    check_eq("corr_nib0", nib(0), 4'b1001);
`ifdef VMD_ON_WALL_EN
    check_eq("corr_on_wall0", on_wall[0], 1'b1);
`endif

    // Tunnel wrap on both sides
    clear_map(1'b0);
    park();
    set_pos(0, 0, 29);
    set_pos(1, 79, 29);
    map[29][79] = 1'b1; map[29][0] = 1'b1;
    run_pass("tunnel", lat);
    check_eq("tunnel_left_nib0", nib(0), 4'b1000);
    check_eq("tunnel_right_nib1", nib(1), 4'b0001);

    // Top and bottom rows: reads beyond the edge are discarded
    clear_map(1'b0);
    park();
    set_pos(0, 5, 0);
    set_pos(1, 5, 59);
    map[0][5] = 1'b1; map[1][5] = 1'b1; map[58][5] = 1'b1; map[59][5] = 1'b1;
    addr_bad = 0;
    run_pass("vedge", lat);
    check_eq("vedge_top_nib0", nib(0), 4'b0100);
    check_eq("vedge_bot_nib1", nib(1), 4'b0010);
    check_eq("vedge_addr_range", addr_bad, 0);

    // Restart ignored while busy, position change ignored mid-pass
    clear_map(1'b0);
    map[10][9] = 1'b1; map[10][11] = 1'b1;
    park();
    set_pos(0, 10, 10);
    n_done = 0;
    first_done = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = c;
      end
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
      if (c == 8) set_pos(0, 87, 10);
      @(negedge clk);
    end
    check_eq("proto_done_count", n_done, 1);
    check_eq("proto_done_cycle", first_done, 21);
    check_eq("proto_snapshot_nib0", nib(0), 4'b1001);
    set_pos(0, 10, 10);

    // Reset seven cycles into a pass
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_moves_flat", moves_flat, '0);
    check_eq("midrst_moves_valid", moves_valid, '0);
    check_eq("midrst_mem_en", mem_en, 1'b0);
    rst = 1'b0;

    // Out-of-range column on an all-open map
    clear_map(1'b1);
    park();
    pos_x_flat[0 +: X_W] = X_W'(700);
    pos_y_flat[0 +: Y_W] = Y_W'(85);
    set_pos(1, 10, 10);
    addr_bad = 0;
    run_pass("oor", lat);
    check_eq("oor_nib0", nib(0), 4'b0000);
    check_eq("oor_nib1", nib(1), 4'b1111);
    check_eq("oor_valid", moves_valid, 5'b11111);
    check_eq("oor_addr_range", addr_bad, 0);
`ifdef VMD_ON_WALL_EN
    check_eq("oor_on_wall1", on_wall[1], 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
